next_pc_unit: RTL and testbench
===============================

# next_pc_unit

Sequential program-counter and branch-resolution block for the single-cycle ARM (LEGv8) datapath. It consumes the branch-related control signals produced by the `control` decoder, together with the instruction's offset fields, register data and ALU flags. Each cycle it selects and registers the next PC. It also owns the architectural NZCV flags register, supplies the BL link address, and detects the branch-to-self end-of-program idiom.

## Interface
- `PC_RESET`, default 64'h0: PC value loaded on reset.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `uncondBranch`  in  1  B/BL taken unconditionally.
- `cbBranch`  in  1  B.cond instruction.
- `cbzBranch`  in  1  CBZ instruction.
- `setPCReg`  in  1  BR; target is `regData`.
- `link`  in  1  BL; drive `linkAddr` for X30 write.
- `setFlags`  in  1  latch `aluFlags` into the flags register this edge.
- `stall`  in  1  hold PC and flags this cycle.
- `brAddr26`  in  26  instruction[25:0], B/BL word offset.
- `condAddr19`  in  19  instruction[23:5], CB/CBZ word offset.
- `cond`  in  4  instruction[3:0], B.cond condition code.
- `regData`  in  64  register-file read data (BR target, or CBZ operand).
- `aluFlags`  in  4  {N,Z,C,V} from the ALU this cycle.
- `pc`  out  64  current instruction address.
- `linkAddr`  out  64  `pc + 4`.
- `flags`  out  4  registered {N,Z,C,V}.
- `branchTaken`  out  1  combinational: a redirect is selected this cycle.
- `halted`  out  1  high in HALT state.

## Operation
- States: RUN, HALT. Reset enters RUN.
- RUN: next PC priority, evaluated combinationally:
  1. `setPCReg` -> `regData`.
  2. `uncondBranch` -> `pc + (sext(brAddr26) << 2)`.
  3. `cbzBranch` and `regData == 0` -> `pc + (sext(condAddr19) << 2)`.
  4. `cbBranch` and condition true -> `pc + (sext(condAddr19) << 2)`.
  5. Otherwise -> `pc + 4`.
- All adds are modulo 2^64. Offsets are sign-extended from bit 25 or bit 18 before the shift.
- Conditions are evaluated on the registered `flags`, never on `aluFlags`:
  - EQ(0) Z; NE(1) !Z; HS(2) C; LO(3) !C; MI(4) N; PL(5) !N; VS(6) V; VC(7) !V.
  - HI(8) C&!Z; LS(9) !C|Z; GE(10) N==V; LT(11) N!=V; GT(12) !Z&(N==V); LE(13) Z|(N!=V).
  - AL(14) and NV(15) are always true.
- `setFlags` writes `aluFlags` to `flags` at the edge, regardless of branching.
  - If `setFlags` and `cbBranch` are both high, the branch uses the old flags.
- `stall` high: PC and flags hold. `branchTaken` is still computed. Stall has no effect in HALT.
- HALT entry: in RUN with `uncondBranch` high, `link` low, `brAddr26 == 0`, and `stall` low. The PC is not updated on that edge.
- HALT: PC and flags frozen. `branchTaken` = 0. Leave only via `reset`.
- `linkAddr` is always `pc + 4`. The register file decides whether to write it, based on `link`.
- Multiple branch controls high together resolve by the priority above; the decoder never produces this.

## Timing
- Reset values: `pc` = `PC_RESET`; `flags` = 4'b0000; `halted` = 0; state = RUN; `linkAddr` = `PC_RESET + 4`.
- Reset asserted mid-program or in HALT: everything returns to the reset values at the next edge, overriding `stall` and all branch inputs.
- Next-PC latency: one cycle. Inputs sampled at edge k appear on `pc` after edge k.
- `branchTaken` and `linkAddr` are combinational from the current `pc`, `flags` and inputs.
- Flags written at edge k are visible to a B.cond in cycle k+1.

## Structure
- Package `cpu_pkg` holds:
  - `cond_t` enum with the 16 condition codes.
  - `pc_state_t` enum (RUN, HALT).
  - Localparams for the flag bit positions N=3, Z=2, C=1, V=0.
- Sub-module `cond_eval`: combinational, `cond` and `flags` in, `condTrue` out.
- Top level holds the PC register, flags register, state register and next-PC mux.

## Test plan
- Reset then 3 idle cycles, `PC_RESET`=0 -> `pc` = 0, 4, 8, 12; `flags` = 0; `halted` = 0.
- At pc=0x40, `uncondBranch`, `brAddr26`=26'h3FFFFFE (-2) -> next `pc` = 0x38. At pc=0x38, `link`=1 -> `linkAddr` = 0x3C.
- `setFlags` with `aluFlags`=4'b1000 (N=1,V=0), then next cycle `cbBranch`, `cond`=LT, `condAddr19`=5 -> `pc` advances by 20. Same with `cond`=GE -> `pc` + 4.
- `cbzBranch`, `regData`=0, `condAddr19`=3 -> `pc` + 12. `regData`=1 -> `pc` + 4. `setPCReg`, `regData`=0x1000 -> `pc` = 0x1000.
- `stall` held 2 cycles at pc=0x20 with `setFlags`=1 -> `pc` stays 0x20 and `flags` unchanged. Release -> `pc` = 0x24.
- `uncondBranch`, `brAddr26`=0 at pc=0x80 -> `halted`=1 and `pc` stays 0x80 for 5 cycles despite inputs. `reset` -> `pc` = 0 and `halted` = 0 after one edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the LEGv8 program-counter / branch logic.
package cpu_pkg;

  // B.cond condition codes, encoded exactly as instruction[3:0].
  typedef enum logic [3:0] {
    COND_EQ = 4'd0,
    COND_NE = 4'd1,
    COND_HS = 4'd2,
    COND_LO = 4'd3,
    COND_MI = 4'd4,
    COND_PL = 4'd5,
    COND_VS = 4'd6,
    COND_VC = 4'd7,
    COND_HI = 4'd8,
    COND_LS = 4'd9,
    COND_GE = 4'd10,
    COND_LT = 4'd11,
    COND_GT = 4'd12,
    COND_LE = 4'd13,
    COND_AL = 4'd14,
    COND_NV = 4'd15
  } cond_t;

  // Sequencer state: running normally, or parked after a branch-to-self.
  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } pc_state_t;

  // Bit positions inside the {N,Z,C,V} flag nibble.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_eval.sv
// Combinational evaluation of a B.cond condition code against the NZCV flags.
module cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       condTrue
);

  logic n;
  logic z;
  logic c;
  logic v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  // Decode the condition code into a single taken/not-taken bit; AL and NV both always pass.
  always_comb begin
    condTrue = 1'b1;
    case (cond_t'(cond))
      COND_EQ: condTrue = z;
      COND_NE: condTrue = !z;
      COND_HS: condTrue = c;
      COND_LO: condTrue = !c;
      COND_MI: condTrue = n;
      COND_PL: condTrue = !n;
      COND_VS: condTrue = v;
      COND_VC: condTrue = !v;
      COND_HI: condTrue = c && !z;
      COND_LS: condTrue = !c || z;
      COND_GE: condTrue = (n == v);
      COND_LT: condTrue = (n != v);
      COND_GT: condTrue = !z && (n == v);
      COND_LE: condTrue = z || (n != v);
      COND_AL: condTrue = 1'b1;
      COND_NV: condTrue = 1'b1;
      default: condTrue = 1'b1;
    endcase
  end

endmodule

// File: rtl/next_pc_unit.sv
// Program counter, NZCV flag register and branch resolution for the single-cycle LEGv8 datapath.
module next_pc_unit
  import cpu_pkg::*;
#(
  parameter logic [63:0] PC_RESET = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uncondBranch,
  input  logic        cbBranch,
  input  logic        cbzBranch,
  input  logic        setPCReg,
  input  logic        link,
  input  logic        setFlags,
  input  logic        stall,
  input  logic [25:0] brAddr26,
  input  logic [18:0] condAddr19,
  input  logic [3:0]  cond,
  input  logic [63:0] regData,
  input  logic [3:0]  aluFlags,
  output logic [63:0] pc,
  output logic [63:0] linkAddr,
  output logic [3:0]  flags,
  output logic        branchTaken,
  output logic        halted
);

  pc_state_t   state;
  logic        condTrue;
  logic        cbzTaken;
  logic        haltEntry;
  logic [63:0] brOffset;
  logic [63:0] condOffset;
  logic [63:0] nextPc;

  cond_eval condEval (
    .cond     (cond),
    .flags    (flags),
    .condTrue (condTrue)
  );

  assign brOffset   = {{36{brAddr26[25]}}, brAddr26, 2'b00};
  assign condOffset = {{43{condAddr19[18]}}, condAddr19, 2'b00};
  assign cbzTaken   = cbzBranch && (regData == 64'd0);
  assign haltEntry  = (state == RUN) && uncondBranch && !link &&
                      (brAddr26 == 26'd0) && !stall;
  assign linkAddr   = pc + 64'd4;
  assign halted     = (state == HALT);

  // Next-PC priority mux; a parked sequencer never reports a redirect.
  always_comb begin
    nextPc      = pc + 64'd4;
    branchTaken = 1'b0;
    if (state == RUN) begin
      if (setPCReg) begin
        nextPc      = regData;
        branchTaken = 1'b1;
      end else if (uncondBranch) begin
        nextPc      = pc + brOffset;
        branchTaken = 1'b1;
      end else if (cbzTaken) begin
        nextPc      = pc + condOffset;
        branchTaken = 1'b1;
      end else if (cbBranch && condTrue) begin
        nextPc      = pc + condOffset;
        branchTaken = 1'b1;
      end
    end
  end

  // PC, flags and state update; B.cond above always reads the flags from before this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= PC_RESET;
      flags <= 4'b0000;
      state <= RUN;
    end else if (state == RUN && !stall) begin
      if (setFlags) begin
        flags <= aluFlags;
      end
      if (haltEntry) begin
        state <= HALT;
      end else begin
        pc <= nextPc;
      end
    end
  end

endmodule

// File: tb/tb_next_pc_unit.sv
// Randomized scoreboard bench for next_pc_unit against a behavioural PC/flags model.
module tb_next_pc_unit;

  typedef struct {
    logic        rst;
    logic        unc;
    logic        cb;
    logic        cbz;
    logic        setPc;
    logic        lnk;
    logic        setF;
    logic        stl;
    logic [25:0] br26;
    logic [18:0] c19;
    logic [3:0]  cnd;
    logic [63:0] rd;
    logic [3:0]  af;
  } stim_t;

  typedef struct {
    logic        checkBt;
    logic        btExp;
    logic [63:0] pcExp;
    logic [3:0]  flagsExp;
    logic        haltExp;
  } expect_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        uncondBranch;
  logic        cbBranch;
  logic        cbzBranch;
  logic        setPCReg;
  logic        link;
  logic        setFlags;
  logic        stall;
  logic [25:0] brAddr26;
  logic [18:0] condAddr19;
  logic [3:0]  cond;
  logic [63:0] regData;
  logic [3:0]  aluFlags;
  logic [63:0] pc;
  logic [63:0] linkAddr;
  logic [3:0]  flags;
  logic        branchTaken;
  logic        halted;

  expect_t     scoreboard[$];
  int          vectors = 0;
  int          miscompares = 0;

  logic [63:0] modelPc = 64'h0;
  logic [3:0]  modelFlags = 4'h0;
  logic        modelHalted = 1'b0;

  always #5 clk = ~clk;

  next_pc_unit #(.PC_RESET(64'h0)) dut (
    .clk          (clk),
    .reset        (reset),
    .uncondBranch (uncondBranch),
    .cbBranch     (cbBranch),
    .cbzBranch    (cbzBranch),
    .setPCReg     (setPCReg),
    .link         (link),
    .setFlags     (setFlags),
    .stall        (stall),
    .brAddr26     (brAddr26),
    .condAddr19   (condAddr19),
    .cond         (cond),
    .regData      (regData),
    .aluFlags     (aluFlags),
    .pc           (pc),
    .linkAddr     (linkAddr),
    .flags        (flags),
    .branchTaken  (branchTaken),
    .halted       (halted)
  );

  // Architectural meaning of each condition code, written from the flag semantics.
  function automatic bit condHolds(input logic [3:0] code, input logic [3:0] f);
    bit n, z, c, v, signedLess;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    signedLess = (n ^ v);
    case (code)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c & !z;
      4'd9:  return !(c & !z);
      4'd10: return !signedLess;
      4'd11: return signedLess;
      4'd12: return !(z | signedLess);
      4'd13: return z | signedLess;
      default: return 1'b1;
    endcase
  endfunction

  function automatic stim_t idleStim();
    stim_t s;
    s = '{rst: 1'b0, unc: 1'b0, cb: 1'b0, cbz: 1'b0, setPc: 1'b0, lnk: 1'b0,
          setF: 1'b0, stl: 1'b0, br26: 26'd0, c19: 19'd0, cnd: 4'd0,
          rd: 64'd0, af: 4'd0};
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and push the model's prediction for the coming edge.
  task automatic applyStimulus(input stim_t s);
    expect_t     e;
    longint      brOff;
    longint      condOff;
    logic [63:0] target;
    bit          taken;
    bit          toHalt;
    @(negedge clk);
    reset        = s.rst;
    uncondBranch = s.unc;
    cbBranch     = s.cb;
    cbzBranch    = s.cbz;
    setPCReg     = s.setPc;
    link         = s.lnk;
    setFlags     = s.setF;
    stall        = s.stl;
    brAddr26     = s.br26;
    condAddr19   = s.c19;
    cond         = s.cnd;
    regData      = s.rd;
    aluFlags     = s.af;

    brOff   = longint'($signed(s.br26)) * 4;
    condOff = longint'($signed(s.c19)) * 4;
    taken   = 1'b1;
    if (s.setPc)                               target = s.rd;
    else if (s.unc)                            target = modelPc + brOff;
    else if (s.cbz && s.rd == 64'd0)           target = modelPc + condOff;
    else if (s.cb && condHolds(s.cnd, modelFlags)) target = modelPc + condOff;
    else begin
      target = modelPc + 64'd4;
      taken  = 1'b0;
    end
    if (modelHalted) taken = 1'b0;
    toHalt = !modelHalted && s.unc && !s.lnk && s.br26 == 26'd0 && !s.stl;

    e.checkBt = !s.rst;
    e.btExp   = taken;
    if (s.rst) begin
      modelPc     = 64'h0;
      modelFlags  = 4'h0;
      modelHalted = 1'b0;
    end else if (!modelHalted && !s.stl) begin
      if (s.setF) modelFlags = s.af;
      if (toHalt) modelHalted = 1'b1;
      else        modelPc = target;
    end
    e.pcExp    = modelPc;
    e.flagsExp = modelFlags;
    e.haltExp  = modelHalted;
    scoreboard.push_back(e);
  endtask

  // Monitor: sample the combinational redirect late in the cycle, then the registered state after the edge.
  initial begin
    expect_t e;
    forever begin
      @(negedge clk);
      #3;
      if (scoreboard.size() > 0) begin
        e = scoreboard.pop_front();
        if (e.checkBt) checkOutput("branchTaken", {63'd0, branchTaken}, {63'd0, e.btExp});
        @(posedge clk);
        #1;
        checkOutput("pc", pc, e.pcExp);
        checkOutput("flags", {60'd0, flags}, {60'd0, e.flagsExp});
        checkOutput("halted", {63'd0, halted}, {63'd0, e.haltExp});
        checkOutput("linkAddr", linkAddr, e.pcExp + 64'd4);
      end
    end
  end

  initial begin
    stim_t s;
    int    waitCycles;

    // Reset, then three idle cycles.
    s = idleStim(); s.rst = 1'b1;
    applyStimulus(s);
    applyStimulus(s);
    s = idleStim();
    repeat (3) applyStimulus(s);

    // Backward unconditional branch from 0x40, then a BL-style cycle at 0x38.
    s = idleStim(); s.setPc = 1'b1; s.rd = 64'h40; applyStimulus(s);
    s = idleStim(); s.unc = 1'b1; s.br26 = 26'h3FFFFFE; applyStimulus(s);
    s = idleStim(); s.lnk = 1'b1; applyStimulus(s);

    // Flags written one cycle, consumed by B.cond LT (taken) and GE (not taken).
    s = idleStim(); s.setF = 1'b1; s.af = 4'b1000; applyStimulus(s);
    s = idleStim(); s.cb = 1'b1; s.cnd = 4'd11; s.c19 = 19'd5; applyStimulus(s);
    s = idleStim(); s.setF = 1'b1; s.af = 4'b1000; applyStimulus(s);
    s = idleStim(); s.cb = 1'b1; s.cnd = 4'd10; s.c19 = 19'd5; applyStimulus(s);

    // Same-edge setFlags and B.cond: branch must see the old flags.
    s = idleStim(); s.cb = 1'b1; s.cnd = 4'd0; s.c19 = 19'd7; s.setF = 1'b1; s.af = 4'b0100;
    applyStimulus(s);

    // CBZ taken and not taken, then BR.
    s = idleStim(); s.cbz = 1'b1; s.rd = 64'd0; s.c19 = 19'd3; applyStimulus(s);
    s = idleStim(); s.cbz = 1'b1; s.rd = 64'd1; s.c19 = 19'd3; applyStimulus(s);
    s = idleStim(); s.setPc = 1'b1; s.rd = 64'h1000; applyStimulus(s);

    // Stall with setFlags held for two cycles at 0x20, then release.
    s = idleStim(); s.setPc = 1'b1; s.rd = 64'h20; applyStimulus(s);
    s = idleStim(); s.stl = 1'b1; s.setF = 1'b1; s.af = 4'b0011; s.unc = 1'b1; s.br26 = 26'd8;
    applyStimulus(s);
    applyStimulus(s);
    s = idleStim(); applyStimulus(s);

    // Branch-to-self halts at 0x80; random inputs must not move it; reset recovers.
    s = idleStim(); s.setPc = 1'b1; s.rd = 64'h80; applyStimulus(s);
    s = idleStim(); s.unc = 1'b1; applyStimulus(s);
    for (int i = 0; i < 5; i++) begin
      s = idleStim();
      s.setPc = 1'($urandom); s.unc = 1'($urandom); s.cb = 1'($urandom);
      s.cbz = 1'($urandom); s.setF = 1'($urandom); s.stl = 1'($urandom);
      s.rd = {$urandom, $urandom}; s.af = 4'($urandom); s.br26 = 26'($urandom);
      applyStimulus(s);
    end
    s = idleStim(); s.rst = 1'b1; applyStimulus(s);

    // Randomized traffic with occasional resets and halts.
    for (int i = 0; i < 400; i++) begin
      s = idleStim();
      s.rst   = ($urandom_range(0, 63) == 0);
      s.setPc = ($urandom_range(0, 15) == 0);
      s.unc   = ($urandom_range(0, 5) == 0);
      s.cb    = ($urandom_range(0, 2) == 0);
      s.cbz   = ($urandom_range(0, 4) == 0);
      s.lnk   = 1'($urandom);
      s.setF  = 1'($urandom);
      s.stl   = ($urandom_range(0, 7) == 0);
      s.br26  = ($urandom_range(0, 19) == 0) ? 26'd0 : 26'($urandom);
      s.c19   = 19'($urandom);
      s.cnd   = 4'($urandom);
      s.rd    = ($urandom_range(0, 2) == 0) ? 64'd0 : {$urandom, $urandom};
      s.af    = 4'($urandom);
      applyStimulus(s);
    end

    waitCycles = 0;
    while (scoreboard.size() > 0 && waitCycles < 20) begin
      @(posedge clk);
      waitCycles++;
    end
    repeat (2) @(posedge clk);
    vectors++;
    if (scoreboard.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", scoreboard.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
